// File: rtl/parallel_sum_pkg.sv
// Width and level-count helpers shared by the parallel_sum adder tree.
package parallel_sum_pkg;

    function automatic int unsigned num_levels(input int unsigned num_in);
        return $clog2(num_in);
    endfunction

    function automatic int unsigned level_width(input int unsigned in_w, input int unsigned level);
        return in_w + level;
    endfunction

    function automatic int unsigned level_lanes(input int unsigned num_in, input int unsigned level);
        return num_in >> level;
    endfunction

    function automatic int unsigned out_width(input int unsigned in_w, input int unsigned num_in);
        return level_width(in_w, num_levels(num_in));
    endfunction

endpackage

// File: rtl/parallel_sum_add_stage.sv
// One registered pairwise-add level of the parallel_sum tree; each sum is one bit wider than its operands.
module add_stage #(
    parameter int unsigned LANES  = 2,
    parameter int unsigned W      = 32,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      adv,
    input  logic                      in_valid,
    input  logic [LANES-1:0][W-1:0]   in_data,
    output logic                      out_valid,
    output logic [LANES/2-1:0][W:0]   out_data
);

    localparam int unsigned WO = W + 1;

    logic [LANES/2-1:0][W:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < LANES / 2; i++) begin
            if (SIGNED) begin
                sum[i] = WO'($signed(in_data[2*i])) + WO'($signed(in_data[2*i+1]));
            end else begin
                sum[i] = WO'(in_data[2*i]) + WO'(in_data[2*i+1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
        end
    end

    // Data path carries no reset; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (adv) begin
            out_data <= sum;
        end
    end

endmodule

// File: rtl/parallel_sum.sv
// Pipelined adder tree summing NUM_IN lanes, one vector per cycle with a global stall.
// Optional macro PARALLEL_SUM_ACC_EN adds in_last and a multi-beat accumulator after the tree.
module parallel_sum
    import parallel_sum_pkg::*;
#(
    parameter int unsigned NUM_IN = 256,
    parameter int unsigned IN_W   = 32,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned ACC_W  = 48,
    localparam int unsigned OUT_W = out_width(IN_W, NUM_IN),
`ifdef PARALLEL_SUM_ACC_EN
    localparam int unsigned RES_W = ACC_W
`else
    localparam int unsigned RES_W = OUT_W
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_IN-1:0][IN_W-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
`ifdef PARALLEL_SUM_ACC_EN
    input  logic                          in_last,
`endif
    output logic [RES_W-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned LEVELS = num_levels(NUM_IN);

    if ((NUM_IN < 2) || (NUM_IN > 1024) || ((NUM_IN & (NUM_IN - 1)) != 0)) begin : g_bad_num_in
        $error("parallel_sum: NUM_IN must be a power of two in 2..1024");
    end
    if (ACC_W < OUT_W) begin : g_bad_acc_w
        $error("parallel_sum: ACC_W must be >= OUT_W");
    end

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [NUM_IN-1:0][IN_W-1:0] in_reg;
    logic                        in_reg_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_reg_valid <= 1'b0;
        end else if (adv) begin
            in_reg_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            in_reg <= in_data;
        end
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int unsigned LANES = level_lanes(NUM_IN, l);
        localparam int unsigned W     = level_width(IN_W, l);

        logic [LANES-1:0][W-1:0]   src;
        logic                      src_valid;
        logic [LANES/2-1:0][W:0]   data;
        logic                      valid;

        if (l == 0) begin : g_first
            assign src       = in_reg;
            assign src_valid = in_reg_valid;
        end else begin : g_next
            assign src       = g_lvl[l-1].data;
            assign src_valid = g_lvl[l-1].valid;
        end

        add_stage #(
            .LANES  (LANES),
            .W      (W),
            .SIGNED (SIGNED)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .in_valid  (src_valid),
            .in_data   (src),
            .out_valid (valid),
            .out_data  (data)
        );
    end

    logic [OUT_W-1:0] tree_data;
    logic             tree_valid;
    assign tree_data  = g_lvl[LEVELS-1].data[0];
    assign tree_valid = g_lvl[LEVELS-1].valid;

`ifdef PARALLEL_SUM_ACC_EN
    // in_last rides a shift register alongside the tree so it lines up with tree_valid.
    logic [LEVELS:0] last_pipe;

    always_ff @(posedge clk) begin
        if (adv) begin
            last_pipe <= {last_pipe[LEVELS-1:0], in_last};
        end
    end

    logic [ACC_W-1:0] tree_ext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] res;
    logic             res_valid;

    if (SIGNED) begin : g_ext_s
        assign tree_ext = ACC_W'($signed(tree_data));
    end else begin : g_ext_u
        assign tree_ext = ACC_W'(tree_data);
    end

    assign acc_sum = acc + tree_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            res       <= '0;
            res_valid <= 1'b0;
        end else if (adv) begin
            res_valid <= tree_valid && last_pipe[LEVELS];
            if (tree_valid) begin
                if (last_pipe[LEVELS]) begin
                    acc <= '0;
                    res <= acc_sum;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign out_valid = res_valid;
    assign out_data  = res;
`else
    assign out_valid = tree_valid;
    assign out_data  = tree_valid ? tree_data : '0;
`endif

endmodule

// File: tb/tb_parallel_sum.sv
// Directed self-checking bench for parallel_sum at default parameters plus a SIGNED=1 instance.
`timescale 1ns/1ps
module tb_parallel_sum;

    localparam int unsigned NUM_IN = 256;
    localparam int unsigned IN_W   = 32;
`ifdef PARALLEL_SUM_ACC_EN
    localparam int unsigned RES_W  = 48;
    localparam int unsigned LAT    = 10;
`else
    localparam int unsigned RES_W  = 40;
    localparam int unsigned LAT    = 9;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst_n;
    logic [NUM_IN-1:0][IN_W-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [RES_W-1:0]            out_data;
    logic                        out_valid;
    logic                        out_ready;

    logic [NUM_IN-1:0][IN_W-1:0] s_in_data;
    logic                        s_in_valid;
    logic                        s_in_ready;
    logic [RES_W-1:0]            s_out_data;
    logic                        s_out_valid;
    logic                        s_out_ready;

`ifdef PARALLEL_SUM_ACC_EN
    logic in_last;
    logic s_in_last;
`endif

    int checks   = 0;
    int failures = 0;

    logic [RES_W-1:0] exp_q[$];

    parallel_sum #(.NUM_IN(NUM_IN), .IN_W(IN_W), .SIGNED(1'b0), .ACC_W(48)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef PARALLEL_SUM_ACC_EN
        .in_last   (in_last),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    parallel_sum #(.NUM_IN(NUM_IN), .IN_W(IN_W), .SIGNED(1'b1), .ACC_W(48)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (s_in_data),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
`ifdef PARALLEL_SUM_ACC_EN
        .in_last   (s_in_last),
`endif
        .out_data  (s_out_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RES_W-1:0] model_sum(input logic [NUM_IN-1:0][IN_W-1:0] v);
        logic [RES_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_IN; i++) s += RES_W'(v[i]);
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NUM_IN; i++) in_data[i] = $urandom();
    endtask

    task automatic fill_const(input logic [IN_W-1:0] val);
        for (int i = 0; i < NUM_IN; i++) in_data[i] = val;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        s_in_valid = 1'b0;
        s_out_ready = 1'b1;
        in_data = '0;
        s_in_data = '0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data: got %0h expected 0", out_data);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_full_scale();
        logic [RES_W-1:0] exp;
        exp = RES_W'(40'hFF_FFFF_FF00);
        fill_const(32'hFFFF_FFFF);
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_scale_in_ready: got %b expected 1", in_ready);
        end
        for (int n = 1; n <= int'(LAT) + 1; n++) begin
            tick();
            if (n == 1) in_valid = 1'b0;
            checks++;
            if (out_valid !== (n == int'(LAT))) begin
                failures++;
                $display("FAIL full_scale_latency: cycle %0d got out_valid %b expected %b",
                         n, out_valid, (n == int'(LAT)));
            end
            if (n == int'(LAT)) begin
                checks++;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL full_scale_data: got %0h expected %0h", out_data, exp);
                end
            end
        end
    endtask

    task automatic test_signed_min();
        logic [RES_W-1:0] exp;
        int seen;
        exp = RES_W'($signed(40'h80_0000_0000));
        seen = 0;
        for (int i = 0; i < NUM_IN; i++) s_in_data[i] = 32'h8000_0000;
        s_in_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) s_in_valid = 1'b0;
            if (s_out_valid === 1'b1 && seen == 0) begin
                seen = n;
                checks++;
                if (s_out_data !== exp) begin
                    failures++;
                    $display("FAIL signed_min_data: got %0h expected %0h", s_out_data, exp);
                end
            end
        end
        checks++;
        if (seen != int'(LAT)) begin
            failures++;
            $display("FAIL signed_min_latency: got %0d expected %0d", seen, LAT);
        end
    endtask

    task automatic test_backpressure();
        int sent, got, cyc;
        bit accepted;
        logic [RES_W-1:0] exp;
        sent = 0;
        got = 0;
        cyc = 0;
        exp_q.delete();
        fill_random();
        while (got < 100 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 100);
            accepted = 1'b0;
            #3;
            if (in_valid && in_ready) begin
                exp_q.push_back(model_sum(in_data));
                sent++;
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL backpressure_extra: got %0h expected no result", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp) begin
                        failures++;
                        $display("FAIL backpressure_data: result %0d got %0h expected %0h", got, out_data, exp);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (accepted) fill_random();
        end
        checks++;
        if (got != 100 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_count: got %0d results, %0d pending, expected 100 and 0", got, exp_q.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_dup: got out_valid %b expected 0", out_valid);
            end
        end
    endtask

    task automatic test_stall();
        int sent, got, cyc;
        bit accepted;
        logic prev_hold;
        logic [RES_W-1:0] prev_data;
        logic [RES_W-1:0] exp;
        sent = 0;
        got = 0;
        cyc = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        exp_q.delete();
        fill_const(32'd1);
        while (got < 12 && cyc < 200) begin
            out_ready = (cyc >= 20);
            in_valid = (sent < 12);
            accepted = 1'b0;
            #3;
            if (prev_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold: got valid %b data %0h expected 1 %0h", out_valid, out_data, prev_data);
                end
            end
            if (!out_ready) begin
                checks++;
                if (in_ready !== !out_valid) begin
                    failures++;
                    $display("FAIL stall_in_ready: got %b expected %b", in_ready, !out_valid);
                end
            end
            if (cyc == 20) begin
                checks++;
                if (sent != int'(LAT)) begin
                    failures++;
                    $display("FAIL stall_fill: got %0d accepted expected %0d", sent, LAT);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(RES_W'(256 * (sent + 1)));
                sent++;
                accepted = 1'b1;
            end
            if (out_valid && out_ready) begin
                checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (out_data !== exp) begin
                    failures++;
                    $display("FAIL stall_data: result %0d got %0h expected %0h", got, out_data, exp);
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            cyc++;
            if (accepted) fill_const(IN_W'(sent + 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 12) begin
            failures++;
            $display("FAIL stall_count: got %0d expected 12", got);
        end
    endtask

    task automatic test_reset_midstream();
        int seen;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            fill_random();
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_flush: cycle %0d got out_valid %b expected 0", n, out_valid);
            end
        end
        seen = 0;
        fill_const(32'd3);
        in_valid = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 1) in_valid = 1'b0;
            if (out_valid === 1'b1 && seen == 0) begin
                seen = n;
                checks++;
                if (out_data !== RES_W'(768)) begin
                    failures++;
                    $display("FAIL midreset_data: got %0h expected 300", out_data);
                end
            end
        end
        checks++;
        if (seen != int'(LAT)) begin
            failures++;
            $display("FAIL midreset_latency: got %0d expected %0d", seen, LAT);
        end
    endtask

`ifdef PARALLEL_SUM_ACC_EN
    task automatic test_accumulate();
        int pulses;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int b = 0; b < 4; b++) begin
            fill_const((b == 3) ? 32'd2 : 32'd1);
            in_last = (b >= 2);
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b1;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (pulses == 0 && out_data !== 48'd768) begin
                    failures++;
                    $display("FAIL acc_total: got %0h expected 300", out_data);
                end else if (pulses == 1 && out_data !== 48'd512) begin
                    failures++;
                    $display("FAIL acc_restart: got %0h expected 200", out_data);
                end
                pulses++;
            end
            tick();
        end
        checks++;
        if (pulses != 2) begin
            failures++;
            $display("FAIL acc_pulses: got %0d expected 2", pulses);
        end
    endtask
`endif

    initial begin
`ifdef PARALLEL_SUM_ACC_EN
        in_last = 1'b1;
        s_in_last = 1'b1;
`endif
        test_reset();
        test_full_scale();
        test_signed_min();
        test_backpressure();
        test_stall();
        test_reset_midstream();
`ifdef PARALLEL_SUM_ACC_EN
        test_accumulate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
